// File: rtl/soc_pkg.sv
// Shared SoC definitions: instruction-memory owner encoding and default port widths.
package soc_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } owner_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int STARVE_W       = 8;
endpackage

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for a single-port instruction memory with 1-cycle read latency.
// Define IMEM_ARB_RR_EN for round-robin on contention; default is fetch-first priority.
module imem_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic                  f_flush,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  input  logic                  l_lock,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] WAIT_LIM = STARVE_W'(MAX_WAIT);

  owner_e              state;
  owner_e              owner;
  logic                f_tag;
  logic                l_tag;
  logic [STARVE_W-1:0] starve;

  // Lock and starvation only matter when both ports want the memory this cycle.
  function automatic owner_e pick(input logic fr, input logic lr, input owner_e last,
                                  input logic lock, input logic starved);
    owner_e res;
    logic   flip;
    res = IDLE;
`ifdef IMEM_ARB_RR_EN
    flip = (last == FETCH);
`else
    flip = 1'b0;
`endif
    if (fr && lr) begin
      if ((last == LOAD && lock) || starved || flip) res = LOAD;
      else                                           res = FETCH;
    end else if (fr) begin
      res = FETCH;
    end else if (lr) begin
      res = LOAD;
    end
    return res;
  endfunction

  always_comb begin
    owner = IDLE;
    if (reset_n) owner = pick(f_req, l_req, state, l_lock, starve >= WAIT_LIM);
  end

  assign f_gnt     = (owner == FETCH);
  assign l_gnt     = (owner == LOAD);
  assign mem_en    = f_gnt | l_gnt;
  assign mem_we    = l_gnt & l_we;
  assign mem_addr  = l_gnt ? l_addr : f_addr;
  assign mem_wdata = l_gnt ? l_wdata : '0;

  // A flush also kills a fetch read that is returning this very cycle.
  assign f_rvalid  = f_tag & ~f_flush;
  assign l_rvalid  = l_tag;
  assign f_rdata   = mem_rdata;
  assign l_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      f_tag  <= 1'b0;
      l_tag  <= 1'b0;
      starve <= '0;
    end else begin
      state <= owner;
      f_tag <= f_gnt & ~f_flush;
      l_tag <= l_gnt & ~l_we;
      if (l_req && !l_gnt) starve <= (starve == '1) ? starve : starve + 1'b1;
      else                 starve <= '0;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboarded bench for imem_arbiter: directed scenarios then random traffic against a
// behavioural model (port rules + word memory); honours IMEM_ARB_RR_EN like the design.
module tb_imem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          f_req = 1'b0, f_flush = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [AW-1:0] f_addr = '0, l_addr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
  logic [DW-1:0] f_rdata, l_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hC0DE0000 ^ (a * 32'h9E3779B1);
  endfunction

  // Device memory: 256 words, unwritten words read as init_word(index).
  logic [DW-1:0] dev_mem [256];
  logic [255:0]  dev_wr = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        dev_mem[mem_addr[9:2]] <= mem_wdata;
        dev_wr[mem_addr[9:2]]  <= 1'b1;
      end else begin
        mem_rdata <= dev_wr[mem_addr[9:2]] ? dev_mem[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
      end
    end
  end

  // Reference memory, updated by the model from the requester side.
  logic [DW-1:0] ref_mem [256];
  logic [255:0]  ref_wr = '0;
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_word(int'(a[9:2]));
  endfunction

  typedef struct {
    logic          fg, lg, en, we, frv, lrv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, fd, ld;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model state: last memory owner (0 none, 1 fetch, 2 loader), loader wait count, pending reads.
  int            last = 0;
  int            waitc = 0;
  bit            fpend = 0, lpend = 0;
  logic [DW-1:0] fpd = '0, lpd = '0;

  task automatic cyc(input bit rst, input bit fr, input logic [AW-1:0] fa, input bit ff,
                     input bit lr, input bit lw, input logic [AW-1:0] la,
                     input logic [DW-1:0] lwd, input bit lk);
    exp_t e;
    bit   loader_first, rr_flip;
    @(posedge clk); #1;
    reset_n = !rst; f_req = fr; f_addr = fa; f_flush = ff;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd; l_lock = lk;
    e = '{fg: 0, lg: 0, en: 0, we: 0, frv: 0, lrv: 0, addr: '0, wdata: '0, fd: '0, ld: '0};
    if (rst) begin
      last = 0; waitc = 0; fpend = 0; lpend = 0;
    end else begin
      e.frv = fpend && !ff; e.fd = fpd;
      e.lrv = lpend;        e.ld = lpd;
`ifdef IMEM_ARB_RR_EN
      rr_flip = (last == 1);
`else
      rr_flip = 0;
`endif
      loader_first = (last == 2 && lk) || (waitc >= MW) || rr_flip;
      if (fr && lr) begin
        e.lg = loader_first; e.fg = !loader_first;
      end else begin
        e.fg = fr; e.lg = lr;
      end
      e.en = e.fg || e.lg;
      e.we = e.lg && lw;
      e.addr = e.lg ? la : fa;
      e.wdata = lwd;
      fpend = e.fg && !ff; fpd = ref_rd(fa);
      lpend = e.lg && !lw; lpd = ref_rd(la);
      if (e.we) begin
        ref_mem[la[9:2]] = lwd;
        ref_wr[la[9:2]] = 1'b1;
      end
      waitc = (lr && !e.lg) ? ((waitc < 255) ? waitc + 1 : 255) : 0;
      last = e.fg ? 1 : (e.lg ? 2 : 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, 0, 0, '0, '0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("f_gnt", 64'(f_gnt), 64'(e.fg));
        chk("l_gnt", 64'(l_gnt), 64'(e.lg));
        chk("mem_en", 64'(mem_en), 64'(e.en));
        chk("f_rvalid", 64'(f_rvalid), 64'(e.frv));
        chk("l_rvalid", 64'(l_rvalid), 64'(e.lrv));
        if (e.en) begin
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
        end
        if (e.we)  chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        if (e.frv) chk("f_rdata", 64'(f_rdata), 64'(e.fd));
        if (e.lrv) chk("l_rdata", 64'(l_rdata), 64'(e.ld));
      end
    end
  end

  initial begin : stim
    cyc(1, 0, '0, 0, 0, 0, '0, '0, 0);
    cyc(1, 1, 'h40, 0, 1, 0, 'h44, '0, 1);
    idle();
    // Fetch stream, one grant per cycle
    cyc(0, 1, 'h0, 0, 0, 0, '0, '0, 0);
    cyc(0, 1, 'h4, 0, 0, 0, '0, '0, 0);
    cyc(0, 1, 'h8, 0, 0, 0, '0, '0, 0);
    idle();
    // Four contended cycles from IDLE
    for (int i = 0; i < 4; i++) cyc(0, 1, AW'(32'h40 + 4 * i), 0, 1, 0, AW'(32'h80 + 4 * i), '0, 0);
    idle();
    // Locked loader writes hold the port against fetch
    cyc(0, 0, '0, 0, 1, 1, 'h100, 32'hDEADBEEF, 1);
    cyc(0, 1, 'h10, 0, 1, 1, 'h104, 32'hDEADBEEF, 1);
    cyc(0, 1, 'h14, 0, 0, 0, '0, '0, 0);
    cyc(0, 0, '0, 0, 1, 0, 'h100, '0, 0);
    cyc(0, 0, '0, 0, 1, 0, 'h104, '0, 0);
    idle();
    // Flush kills both the returning fetch and the one granted alongside it
    cyc(0, 1, 'h20, 0, 0, 0, '0, '0, 0);
    cyc(0, 1, 'h24, 1, 0, 0, '0, '0, 0);
    idle();
    // Reset right after a loader read grant
    cyc(0, 0, '0, 0, 1, 0, 'h100, '0, 0);
    cyc(1, 0, '0, 0, 0, 0, '0, '0, 0);
    cyc(0, 1, 'h30, 0, 1, 0, 'h34, '0, 1);
    idle();
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
          AW'({$urandom_range(0, 255), 2'b00}), ($urandom_range(0, 7) == 0),
          $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
          AW'({$urandom_range(0, 255), 2'b00}), DW'($urandom), $urandom_range(0, 1) == 1);
    end
    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
